conv_frame_sequencer: RTL and testbench
=======================================

# conv_frame_sequencer

- Sequences one image frame from the pixel buffer into the 5x5 sliding-window generator, one pixel per cycle, in raster order.
- Clears the window generator before each frame and pauses the pixel stream when the downstream convolution engine is not ready.
- Counts the windows the generator emits and signals frame completion.
- Sits between the frame-buffer BRAM and the line-buffer/window stage of the LeNet-5 conv layers.

## Interface
Parameters:
- IMG_WIDTH, 32, pixels per row (≥5)
- IMG_HEIGHT, 32, rows per frame (≥5)
- PIX_BITS, 8, signed pixel width
- ADDR_BITS, 10, buffer address width; must satisfy 2^ADDR_BITS ≥ IMG_WIDTH*IMG_HEIGHT
- CNT_BITS, 16, window-counter width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- abort  in  1  cancel the current frame; honoured in any state except IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when all windows of a frame have been counted
- aborted  out  1  one-cycle pulse when an abort completes
- mem_rd_en  out  1  read strobe to the pixel buffer
- mem_addr  out  ADDR_BITS  read address
- mem_rd_data  in  PIX_BITS  buffer data; valid exactly 1 cycle after mem_rd_en
- win_clr_n  out  1  synchronous active-low clear to the window generator
- win_valid_in  out  1  pixel strobe to the window generator
- win_pix  out  PIX_BITS  pixel to the window generator
- win_valid_out  in  1  window-valid output of the window generator
- down_ready  in  1  convolution engine can accept new windows
- win_count  out  CNT_BITS  windows counted in the current frame

## Operation
- States: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE:
  - start=1 moves to CLEAR.
  - win_count is held until the next CLEAR.
- CLEAR (1 cycle):
  - win_clr_n=0.
  - mem_addr←0 and win_count←0.
  - Moves to STREAM.
- STREAM:
  - When down_ready=1: mem_rd_en=1 and mem_addr advances by 1 on each issued read.
  - When down_ready=0: mem_rd_en=0 and mem_addr holds.
  - After the read of address N−1 is issued (N=IMG_WIDTH*IMG_HEIGHT), moves to DRAIN.
- Pixel path: win_valid_in is mem_rd_en delayed 1 cycle; win_pix = mem_rd_data, driven combinationally in that cycle.
- DRAIN:
  - Issues no reads.
  - Moves to DONE once win_count equals E = (IMG_WIDTH−4)*(IMG_HEIGHT−4), which is 784 at the defaults.
- DONE (1 cycle): done=1, then moves to IDLE.
- Window counting: win_count increments on every win_valid_out=1 in STREAM or DRAIN. It saturates at its maximum value and never wraps.
- Abort:
  - Next state is IDLE and aborted pulses for 1 cycle.
  - An in-flight read is dropped: win_valid_in is forced to 0 in the cycle after the abort.
  - done is not asserted.
- Simultaneous events:
  - abort has priority over every transition, including DRAIN→DONE.
  - start while busy is ignored.
  - start and abort together in IDLE: start wins.

## Timing
- Reset values: state IDLE; busy=0, done=0, aborted=0, mem_rd_en=0, mem_addr=0, win_clr_n=1, win_valid_in=0, win_pix=0, win_count=0.
- Reset asserted mid-frame returns the block to IDLE immediately. No done pulse follows.
- start@t gives:
  - CLEAR@t+1
  - first mem_rd_en@t+2
  - first win_valid_in@t+3
- With down_ready held high, the last read issues at t+1+N. DRAIN begins the following cycle.
- The generator emits each window 1 cycle after its last pixel. Worst-case done ≈ t+N+5.
- When down_ready falls, reads stop the same cycle. Up to 2 further windows can still emit (the in-flight read plus the generator register), so downstream must provide a 2-entry skid.
- busy rises 1 cycle after start is accepted and falls in the cycle after DONE.

## Structure
- Shared package lenet_pkg holds:
  - state encoding localparams (IDLE=0 … DONE=4)
  - the expected-window function (W−4)*(H−4)
  - CLOG2
- One sub-module is natural: sat_counter (saturating up-counter with synchronous clear), used for win_count.
- The address counter and FSM are inline.

## Test plan
- Default parameters, ramp frame (pixel = addr[7:0]), down_ready=1: exactly 1024 reads; win_valid_in first at start+3; done pulses once after win_count=784; busy low the cycle after.
- down_ready toggled 3-low/2-high during STREAM: addresses contiguous 0..1023 with no skips or repeats; ≤2 windows after each down_ready fall; final win_count=784.
- abort issued at address 500: aborted pulses; no done; no win_valid_in in the following cycle; a fresh start clears win_count to 0 and a full frame completes.
- start held high through a frame: only one frame runs; a second frame starts the cycle after DONE returns to IDLE.
- rst_n asserted mid-STREAM (asynchronously, between edges): all outputs reach reset values without waiting for a clock edge; no done after release.
- IMG_WIDTH=IMG_HEIGHT=5, ADDR_BITS=5: 25 reads, win_count=1, done asserted; abort coinciding with DRAIN→DONE gives aborted and no done.

Source files
------------

// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet-5 conv front end: sequencer state encoding
// and frame-geometry helpers.
package lenet_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_CLEAR  = ST_CLEAR,
    S_STREAM = ST_STREAM,
    S_DRAIN  = ST_DRAIN,
    S_DONE   = ST_DONE
  } seq_state_e;

  // A 5x5 window fits (W-4) times across and (H-4) times down.
  function automatic int expected_windows(input int width, input int height);
    return (width - 4) * (height - 4);
  endfunction

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/conv_frame_sequencer.sv
// Streams one raster-order frame from the pixel buffer into the 5x5 window
// generator, throttled by down_ready, and counts the windows that come back.
module conv_frame_sequencer
  import lenet_pkg::*;
#(
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int PIX_BITS   = 8,
  parameter int ADDR_BITS  = 10,
  parameter int CNT_BITS   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic                 mem_rd_en,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic [PIX_BITS-1:0]  mem_rd_data,
  output logic                 win_clr_n,
  output logic                 win_valid_in,
  output logic [PIX_BITS-1:0]  win_pix,
  input  logic                 win_valid_out,
  input  logic                 down_ready,
  output logic [CNT_BITS-1:0]  win_count
);

  localparam int NUM_PIX = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_PIX - 1);
  localparam logic [CNT_BITS-1:0]  EXP_WIN   =
    CNT_BITS'(expected_windows(IMG_WIDTH, IMG_HEIGHT));

  seq_state_e           state_reg, state_next;
  logic [ADDR_BITS-1:0] addr_reg, addr_next;
  logic                 valid_reg;
  logic                 aborted_reg;
  logic                 abort_hit;
  logic                 count_clr;
  logic                 count_en;

  assign abort_hit = abort & (state_reg != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      addr_reg    <= '0;
      valid_reg   <= 1'b0;
      aborted_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      // A read issued in the abort cycle is dropped on the pixel side.
      valid_reg   <= mem_rd_en & ~abort_hit;
      aborted_reg <= abort_hit;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    busy       = (state_reg != S_IDLE);
    done       = 1'b0;
    mem_rd_en  = 1'b0;
    win_clr_n  = 1'b1;
    count_clr  = 1'b0;
    count_en   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_CLEAR;
      end
      S_CLEAR: begin
        win_clr_n  = 1'b0;
        count_clr  = 1'b1;
        addr_next  = '0;
        state_next = S_STREAM;
      end
      S_STREAM: begin
        count_en  = 1'b1;
        mem_rd_en = down_ready;
        if (down_ready) begin
          addr_next = addr_reg + 1'b1;
          if (addr_reg == LAST_ADDR) state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        count_en = 1'b1;
        if (win_count == EXP_WIN) state_next = S_DONE;
      end
      S_DONE: begin
        done       = ~abort;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // Abort overrides every other transition.
    if (abort_hit) state_next = S_IDLE;
  end

  sat_counter #(
    .WIDTH(CNT_BITS)
  ) u_win_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (count_clr),
    .inc  (win_valid_out & count_en),
    .count(win_count)
  );

  assign mem_addr     = addr_reg;
  assign win_valid_in = valid_reg;
  assign win_pix      = valid_reg ? mem_rd_data : '0;
  assign aborted      = aborted_reg;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Bench for conv_frame_sequencer: a 32x32 and a 5x5 instance driven by a
// ramp-pixel memory and a window-generator model, checked against a frame model.
module tb_conv_frame_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start [2];
  logic       abort [2];
  logic       down_ready [2];
  logic       wv_out [2];
  logic       force_wv [2];
  logic [7:0] rd_data [2];
  logic       busy [2], done [2], aborted [2], rd_en [2], clr_n [2], vin [2];
  logic [7:0] pix [2];
  logic [9:0] addr [2];
  logic [15:0] cnt [2];
  logic [9:0] addr0;
  logic [4:0] addr1;
  logic [15:0] cnt0;
  logic [2:0] cnt1;

  assign addr[0] = addr0;
  assign addr[1] = {5'd0, addr1};
  assign cnt[0]  = cnt0;
  assign cnt[1]  = {13'd0, cnt1};

  conv_frame_sequencer dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
    .busy(busy[0]), .done(done[0]), .aborted(aborted[0]),
    .mem_rd_en(rd_en[0]), .mem_addr(addr0), .mem_rd_data(rd_data[0]),
    .win_clr_n(clr_n[0]), .win_valid_in(vin[0]), .win_pix(pix[0]),
    .win_valid_out(wv_out[0]), .down_ready(down_ready[0]), .win_count(cnt0)
  );

  conv_frame_sequencer #(
    .IMG_WIDTH(5), .IMG_HEIGHT(5), .PIX_BITS(8), .ADDR_BITS(5), .CNT_BITS(3)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
    .busy(busy[1]), .done(done[1]), .aborted(aborted[1]),
    .mem_rd_en(rd_en[1]), .mem_addr(addr1), .mem_rd_data(rd_data[1]),
    .win_clr_n(clr_n[1]), .win_valid_in(vin[1]), .win_pix(pix[1]),
    .win_valid_out(wv_out[1]), .down_ready(down_ready[1]), .win_count(cnt1)
  );

  function automatic int wid(input int k);
    return (k == 0) ? 32 : 5;
  endfunction
  function automatic int npix(input int k);
    return wid(k) * wid(k);
  endfunction
  function automatic int ewin(input int k);
    return (wid(k) - 4) * (wid(k) - 4);
  endfunction
  function automatic int cmax(input int k);
    return (k == 0) ? 65535 : 7;
  endfunction

  int n_cmp = 0;
  int n_bad = 0;
  int cycle = 0;

  task automatic chk(input string what, input int k, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cycle %0d: got %0d, expected %0d", what, k, cycle, act, exp);
    end
  endtask

  // Environment: ramp memory with 1-cycle read latency, and a window generator
  // that fires one cycle after each pixel at row>=4, col>=4 of the frame.
  int pcnt [2];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        rd_data[k] <= 8'd0;
        wv_out[k]  <= 1'b0;
        pcnt[k]    <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (rd_en[k]) rd_data[k] <= addr[k][7:0];
        if (!clr_n[k]) begin
          pcnt[k]   <= 0;
          wv_out[k] <= force_wv[k];
        end else if (vin[k]) begin
          pcnt[k]   <= pcnt[k] + 1;
          wv_out[k] <= force_wv[k] ||
                       (((pcnt[k] / wid(k)) >= 4) && ((pcnt[k] % wid(k)) >= 4));
        end else begin
          wv_out[k] <= force_wv[k];
        end
      end
    end
  end

  // Frame model: a frame is "active" from start acceptance; its first cycle is
  // the clear, reads follow until N were issued, then it waits for E windows.
  bit m_active [2], m_in_done [2], m_vin [2], m_abt [2];
  int m_cyc [2], m_reads [2], m_count [2], m_pix [2];
  int rd_seen [2], first_vin [2], done_seen [2], done_cyc [2], abt_seen [2];
  int start_cyc [2], n_starts [2], run_w [2], max_run [2];
  bit prev_dr [2];
  bit e_clr, e_stream, e_drain, e_rd, aborting, goto_done;

  always @(negedge clk) begin
    cycle++;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_active[k] = 0; m_in_done[k] = 0; m_vin[k] = 0; m_abt[k] = 0;
        m_cyc[k] = 0; m_reads[k] = 0; m_count[k] = 0; m_pix[k] = 0;
        prev_dr[k] = 0;
      end else begin
        e_clr    = m_active[k] && (m_cyc[k] == 1);
        e_stream = m_active[k] && (m_cyc[k] >= 2) && (m_reads[k] < npix(k));
        e_drain  = m_active[k] && (m_cyc[k] >= 2) && (m_reads[k] >= npix(k)) && !m_in_done[k];
        e_rd     = e_stream && down_ready[k];

        chk("busy", k, int'(busy[k]), int'(m_active[k]));
        chk("win_clr_n", k, int'(clr_n[k]), int'(!e_clr));
        chk("mem_rd_en", k, int'(rd_en[k]), int'(e_rd));
        if (e_rd && rd_en[k]) chk("mem_addr", k, int'(addr[k]), m_reads[k]);
        chk("done", k, int'(done[k]), int'(m_active[k] && m_in_done[k] && !abort[k]));
        chk("aborted", k, int'(aborted[k]), int'(m_abt[k]));
        chk("win_valid_in", k, int'(vin[k]), int'(m_vin[k]));
        chk("win_pix", k, int'(pix[k]), m_vin[k] ? m_pix[k] : 0);
        chk("win_count", k, int'(cnt[k]), m_count[k]);

        if (rd_en[k]) rd_seen[k]++;
        if (vin[k] && first_vin[k] < 0) first_vin[k] = cycle;
        if (done[k]) begin done_seen[k]++; done_cyc[k] = cycle; end
        if (aborted[k]) abt_seen[k]++;
        if (!down_ready[k] && prev_dr[k]) run_w[k] = 0;
        if (!down_ready[k] && busy[k] && wv_out[k]) begin
          run_w[k]++;
          if (run_w[k] > max_run[k]) max_run[k] = run_w[k];
        end
        prev_dr[k] = down_ready[k];

        aborting  = m_active[k] && abort[k];
        goto_done = e_drain && (m_count[k] == ewin(k));
        if (e_clr) begin
          m_count[k] = 0;
          m_reads[k] = 0;
        end else begin
          if ((e_stream || e_drain) && wv_out[k] && m_count[k] < cmax(k)) m_count[k]++;
          if (e_rd) begin
            m_pix[k] = m_reads[k] % 256;
            m_reads[k]++;
          end
        end
        m_vin[k] = e_rd && !aborting;
        m_abt[k] = aborting;
        if (aborting) begin
          m_active[k] = 0;
        end else if (!m_active[k]) begin
          if (start[k]) begin
            m_active[k] = 1; m_cyc[k] = 1; m_in_done[k] = 0;
            start_cyc[k] = cycle; n_starts[k]++;
          end
        end else if (m_in_done[k]) begin
          m_active[k] = 0;
        end else begin
          if (goto_done) m_in_done[k] = 1;
          m_cyc[k]++;
        end
      end
    end
  end

  int dr_mode [2];
  int pat [2];

  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      pat[k]++;
      case (dr_mode[k])
        0:       down_ready[k] = 1'b1;
        1:       down_ready[k] = (pat[k] % 5) >= 3;
        default: down_ready[k] = $urandom_range(0, 9) < 7;
      endcase
    end
  endtask

  task automatic clear_tally(input int k);
    rd_seen[k] = 0; first_vin[k] = -1; done_seen[k] = 0; abt_seen[k] = 0;
    n_starts[k] = 0; max_run[k] = 0; run_w[k] = 0; pat[k] = 0;
  endtask

  task automatic run_frame(input int k, input int budget);
    int i;
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
    i = 0;
    while (busy[k] && i < budget) begin
      tick();
      i++;
    end
    chk("frame_timeout", k, int'(busy[k]), 0);
  endtask

  task automatic chk_reset_outputs(input string tag, input int k);
    chk({tag, "_busy"}, k, int'(busy[k]), 0);
    chk({tag, "_done"}, k, int'(done[k]), 0);
    chk({tag, "_aborted"}, k, int'(aborted[k]), 0);
    chk({tag, "_rd_en"}, k, int'(rd_en[k]), 0);
    chk({tag, "_addr"}, k, int'(addr[k]), 0);
    chk({tag, "_clr_n"}, k, int'(clr_n[k]), 1);
    chk({tag, "_vin"}, k, int'(vin[k]), 0);
    chk({tag, "_pix"}, k, int'(pix[k]), 0);
    chk({tag, "_count"}, k, int'(cnt[k]), 0);
  endtask

  initial begin
    int i;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; abort[k] = 1'b0; down_ready[k] = 1'b1;
      force_wv[k] = 1'b0; dr_mode[k] = 0;
      clear_tally(k);
    end
    repeat (3) tick();
    chk_reset_outputs("reset", 0);
    chk_reset_outputs("reset", 1);
    rst_n = 1'b1;
    tick();

    // Full ramp frame at full throughput.
    clear_tally(0);
    run_frame(0, 3000);
    chk("ramp_reads", 0, rd_seen[0], 1024);
    chk("ramp_first_vin_lat", 0, first_vin[0] - start_cyc[0], 3);
    chk("ramp_done_count", 0, done_seen[0], 1);
    chk("ramp_done_lat", 0, done_cyc[0] - start_cyc[0], 1029);
    chk("ramp_win_count", 0, int'(cnt[0]), 784);

    // Backpressure: 3 cycles low, 2 high.
    clear_tally(0);
    dr_mode[0] = 1;
    run_frame(0, 5000);
    dr_mode[0] = 0;
    chk("bp_reads", 0, rd_seen[0], 1024);
    chk("bp_win_count", 0, int'(cnt[0]), 784);
    chk("bp_done_count", 0, done_seen[0], 1);
    chk("bp_win_after_fall_le2", 0, int'(max_run[0] <= 2), 1);

    // Abort at address 500, then a fresh full frame.
    clear_tally(0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    i = 0;
    while (!(rd_en[0] && addr[0] == 10'd500) && i < 2000) begin
      tick();
      i++;
    end
    chk("abort_reach_500", 0, int'(rd_en[0] && addr[0] == 10'd500), 1);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    chk("abort_vin_next", 0, int'(vin[0]), 0);
    tick();
    tick();
    chk("abort_pulses", 0, abt_seen[0], 1);
    chk("abort_no_done", 0, done_seen[0], 0);
    chk("abort_idle", 0, int'(busy[0]), 0);
    run_frame(0, 3000);
    chk("after_abort_win_count", 0, int'(cnt[0]), 784);
    chk("after_abort_done", 0, done_seen[0], 1);

    // start held high: second frame begins the cycle after DONE.
    clear_tally(0);
    start[0] = 1'b1;
    i = 0;
    while (done_seen[0] == 0 && i < 3000) begin
      tick();
      i++;
    end
    tick();
    start[0] = 1'b0;
    chk("held_start_count", 0, n_starts[0], 2);
    chk("held_restart_gap", 0, start_cyc[0] - done_cyc[0], 1);
    i = 0;
    while (busy[0] && i < 3000) begin
      tick();
      i++;
    end
    chk("held_second_done", 0, done_seen[0], 2);
    chk("held_win_count", 0, int'(cnt[0]), 784);

    // Asynchronous reset mid-stream, between clock edges.
    clear_tally(0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (100) tick();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst", 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (60) tick();
    chk("async_rst_no_done", 0, done_seen[0], 0);
    chk("async_rst_idle", 0, int'(busy[0]), 0);

    // 5x5 frame: 25 reads, one window.
    clear_tally(1);
    run_frame(1, 200);
    chk("small_reads", 1, rd_seen[1], 25);
    chk("small_win_count", 1, int'(cnt[1]), 1);
    chk("small_done", 1, done_seen[1], 1);
    chk("small_done_lat", 1, done_cyc[1] - start_cyc[1], 30);
    chk("small_first_vin_lat", 1, first_vin[1] - start_cyc[1], 3);

    // Abort in the very cycle DRAIN would move to DONE.
    clear_tally(1);
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    repeat (28) tick();
    abort[1] = 1'b1;
    tick();
    abort[1] = 1'b0;
    tick();
    tick();
    chk("drain_abort_pulses", 1, abt_seen[1], 1);
    chk("drain_abort_no_done", 1, done_seen[1], 0);
    chk("drain_abort_idle", 1, int'(busy[1]), 0);

    // Counter saturation with a runaway generator.
    clear_tally(1);
    force_wv[1] = 1'b1;
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    repeat (40) tick();
    chk("sat_count", 1, int'(cnt[1]), 7);
    chk("sat_still_busy", 1, int'(busy[1]), 1);
    abort[1] = 1'b1;
    tick();
    abort[1] = 1'b0;
    force_wv[1] = 1'b0;
    tick();
    chk("sat_abort_idle", 1, int'(busy[1]), 0);

    // Random start/abort/backpressure on both instances.
    dr_mode[0] = 2;
    dr_mode[1] = 2;
    for (int c = 0; c < 16000; c++) begin
      for (int k = 0; k < 2; k++) begin
        start[k] = $urandom_range(0, 99) < 3;
        abort[k] = $urandom_range(0, (k == 0) ? 3999 : 199) == 0;
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0;
      abort[k] = 1'b0;
    end
    i = 0;
    while ((busy[0] || busy[1]) && i < 4000) begin
      tick();
      i++;
    end
    chk("random_settle", 0, int'(busy[0] || busy[1]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

endmodule
